// File: rtl/permutation_ctrl_if.sv
// permutation_ctrl_if
// Handshake bundle between the top-level ASCON FSM (master) and the
// permutation round scheduler (slave).
//   start_i    : request one permutation run
//   mode_i     : 0 = p^a rounds, 1 = p^b rounds, sampled with start_i
//   abort_i    : cancel the run in progress (only with PERM_ABORT_EN)
//   round_o    : round index for the constant-addition stage
//   sel_init_o : datapath takes the external state this cycle
//   en_state_o : state register write enable
//   busy_o     : run in progress
//   done_o     : one-cycle completion pulse
// Optional feature macro: PERM_ABORT_EN (adds abort_i).
interface permutation_ctrl_if;
    logic       start_i;
    logic       mode_i;
`ifdef PERM_ABORT_EN
    logic       abort_i;
`endif
    logic [3:0] round_o;
    logic       sel_init_o;
    logic       en_state_o;
    logic       busy_o;
    logic       done_o;

`ifdef PERM_ABORT_EN
    modport master (
        output start_i, mode_i, abort_i,
        input  round_o, sel_init_o, en_state_o, busy_o, done_o
    );
    modport slave (
        input  start_i, mode_i, abort_i,
        output round_o, sel_init_o, en_state_o, busy_o, done_o
    );
`else
    modport master (
        output start_i, mode_i,
        input  round_o, sel_init_o, en_state_o, busy_o, done_o
    );
    modport slave (
        input  start_i, mode_i,
        output round_o, sel_init_o, en_state_o, busy_o, done_o
    );
`endif
endinterface

// File: rtl/permutation_ctrl.sv
// permutation_ctrl
// Round scheduler for the ASCON permutation datapath. On start it selects
// the external state for the first round, then enables the state register
// once per clock for NR_A (mode 0) or NR_B (mode 1) rounds, ending on round
// index 11, and pulses done_o one cycle after the final round.
// Ports:
//   clock_i  : system clock, rising edge
//   resetb_i : asynchronous active-low reset
//   bus      : permutation_ctrl_if.slave (start/mode/abort in, round/
//              sel_init/en_state/busy/done out)
// Parameters: NR_A (1..12, default 12), NR_B (1..12, default 6).
// Optional feature macro: PERM_ABORT_EN (abort_i cancels a run in ROUND).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; all outputs low
// ROUND | one permutation round per cycle; state register enabled
// DONE  | one-cycle completion pulse; round_o holds 11
module permutation_ctrl #(
    parameter int NR_A = 12,
    parameter int NR_B = 6
) (
    input  logic               clock_i,
    input  logic               resetb_i,
    permutation_ctrl_if.slave  bus
);

    // Runs always finish on index 11, so shorter runs start later in the
    // constant table.
    localparam logic [3:0] START_A = 4'(12 - NR_A);
    localparam logic [3:0] START_B = 4'(12 - NR_B);
    localparam logic [3:0] LAST_RD = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] counter;
    logic       first_q;
    logic       busy_q;
    logic       en_q;
    logic       done_q;
    logic [3:0] round_q;
    logic [3:0] start_cnt;
    logic       abort;

`ifdef PERM_ABORT_EN
    assign abort = bus.abort_i;
`else
    assign abort = 1'b0;
`endif

    assign start_cnt = bus.mode_i ? START_B : START_A;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state   <= S_IDLE;
            counter <= 4'd0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            round_q <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q  <= 1'b0;
                    round_q <= 4'd0;
                    if (bus.start_i) begin
                        state   <= S_ROUND;
                        counter <= start_cnt;
                        first_q <= 1'b1;
                        busy_q  <= 1'b1;
                        en_q    <= 1'b1;
                        round_q <= start_cnt;
                    end
                end
                S_ROUND: begin
                    first_q <= 1'b0;
                    if (abort) begin
                        state   <= S_IDLE;
                        busy_q  <= 1'b0;
                        en_q    <= 1'b0;
                        round_q <= 4'd0;
                    end else if (counter == LAST_RD) begin
                        state   <= S_DONE;
                        busy_q  <= 1'b0;
                        en_q    <= 1'b0;
                        done_q  <= 1'b1;
                        round_q <= LAST_RD;
                    end else begin
                        counter <= counter + 4'd1;
                        round_q <= counter + 4'd1;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    done_q  <= 1'b0;
                    round_q <= 4'd0;
                end
                default: begin
                    state   <= S_IDLE;
                    first_q <= 1'b0;
                    busy_q  <= 1'b0;
                    en_q    <= 1'b0;
                    done_q  <= 1'b0;
                    round_q <= 4'd0;
                end
            endcase
        end
    end

    assign bus.round_o    = round_q;
    assign bus.sel_init_o = first_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    // Abort must stop the state register within the same cycle, so it gates
    // the registered enable directly.
    assign bus.en_state_o = en_q & ~abort;

endmodule

// File: tb/tb_permutation_ctrl.sv
// tb_permutation_ctrl
// Drives two scheduler instances (default parameters, and NR_A=1/NR_B=12)
// with shared stimulus and compares both against a cycle-index reference
// model every negative clock edge, plus directed literal expectations.
// Optional feature macro: PERM_ABORT_EN.
module tb_permutation_ctrl;

    localparam int NA0 = 12;
    localparam int NB0 = 6;
    localparam int NA1 = 1;
    localparam int NB1 = 12;

    logic clk;
    logic rstb;
    logic start;
    logic mode;
    logic abort;

    int errors = 0;
    int checks = 0;

    permutation_ctrl_if if0 ();
    permutation_ctrl_if if1 ();

    assign if0.start_i = start;
    assign if0.mode_i  = mode;
    assign if1.start_i = start;
    assign if1.mode_i  = mode;
`ifdef PERM_ABORT_EN
    assign if0.abort_i = abort;
    assign if1.abort_i = abort;
`endif

    permutation_ctrl #(.NR_A(NA0), .NR_B(NB0)) dut0 (
        .clock_i (clk),
        .resetb_i(rstb),
        .bus     (if0.slave)
    );

    permutation_ctrl #(.NR_A(NA1), .NR_B(NB1)) dut1 (
        .clock_i (clk),
        .resetb_i(rstb),
        .bus     (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy, en_state, sel_init, done, round[3:0]}
    logic [7:0] act0;
    logic [7:0] act1;
    assign act0 = {if0.busy_o, if0.en_state_o, if0.sel_init_o, if0.done_o, if0.round_o};
    assign act1 = {if1.busy_o, if1.en_state_o, if1.sel_init_o, if1.done_o, if1.round_o};

    // Reference model: p = cycles since the accepted start (0 = idle),
    // n = run length chosen at start. Rounds are p=1..n, done is p=n+1.
    int p0 = 0, n0 = NA0;
    int p1 = 0, n1 = NA1;

    function automatic int next_p(int p, int n, logic st, logic ab);
        if (p == 0)  return st ? 1 : 0;
        if (p <= n)  return ab ? 0 : p + 1;
        return 0;
    endfunction

    function automatic logic [7:0] exp_out(int p, int n, logic ab);
        logic       run;
        logic [3:0] rnd;
        run = (p >= 1) && (p <= n);
        if (run)           rnd = 4'(12 - n + p - 1);
        else if (p == n+1) rnd = 4'd11;
        else               rnd = 4'd0;
        return {run, run && !ab, p == 1, p == n + 1, rnd};
    endfunction

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            p0 <= 0;
            p1 <= 0;
        end else begin
            p0 <= next_p(p0, n0, start, abort);
            p1 <= next_p(p1, n1, start, abort);
            if (p0 == 0 && start) n0 <= mode ? NB0 : NA0;
            if (p1 == 0 && start) n1 <= mode ? NB1 : NA1;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_inst0", act0, exp_out(p0, n0, abort));
        check("model_inst1", act1, exp_out(p1, n1, abort));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_round0(input logic [3:0] r, input string name);
        int w;
        w = 0;
        while (if0.round_o != r && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) check(name, {4'd0, if0.round_o}, {4'd0, r});
    endtask

    initial begin
        rstb  = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        abort = 1'b0;
        #1;
        check("reset_outputs", act0, 8'h00);
        tick(); tick();
        #2 rstb = 1'b1;
        tick();

        // Mode 0, full 12-round run; instance 1 runs its single round.
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            check("p12_round", {4'd0, if0.round_o}, 8'(k - 1));
            check("p12_sel", {7'd0, if0.sel_init_o}, {7'd0, k == 1});
            check("p12_en", {7'd0, if0.en_state_o}, 8'd1);
            if (k == 1) check("na1_round", {3'd0, if1.sel_init_o, if1.round_o}, 8'h1b);
            if (k == 2) check("na1_done", {7'd0, if1.done_o}, 8'd1);
            tick();
        end
        check("p12_done", {if0.busy_o, if0.done_o, 2'b0, if0.round_o}, 8'h4b);
        tick();
        tick();

        // Mode 1, 6 rounds starting at index 6.
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check("p6_round", {4'd0, if0.round_o}, 8'(5 + k));
            tick();
        end
        check("p6_done", {7'd0, if0.done_o}, 8'd1);
        repeat (14) tick();

        // Reset in the middle of a run.
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        wait_round0(4'd5, "wait_round5");
        #2 rstb = 1'b0;
        #1;
        check("async_reset0", act0, 8'h00);
        check("async_reset1", act1, 8'h00);
        tick();
        #2 rstb = 1'b1;
        for (int k = 0; k < 14; k++) begin
            check("no_done_after_reset", {7'd0, if0.done_o}, 8'd0);
            tick();
        end
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        check("restart_round0", {if0.sel_init_o, 3'd0, if0.round_o}, 8'h80);
        repeat (14) tick();

`ifdef PERM_ABORT_EN
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        wait_round0(4'd3, "wait_round3");
        abort = 1'b1;
        #1;
        check("abort_en_low", {7'd0, if0.en_state_o}, 8'd0);
        tick();
        abort = 1'b0;
        check("abort_idle", act0, 8'h00);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("after_abort_round0", {if0.busy_o, 3'd0, if0.round_o}, 8'h80);
        repeat (14) tick();
`endif

        // start held high, mode toggling every cycle.
        start = 1'b1;
        for (int k = 0; k < 45; k++) begin
            mode = k[0];
            tick();
        end
        start = 1'b0;
        mode  = 1'b0;
        repeat (14) tick();

        // Randomized traffic with occasional async resets.
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 3) != 0);
            mode  = $urandom_range(0, 1) == 1;
`ifdef PERM_ABORT_EN
            abort = ($urandom_range(0, 19) == 0);
`endif
            if ($urandom_range(0, 199) == 0) begin
                #2 rstb = 1'b0;
                #3 rstb = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
